array_reverse_ctrl: RTL and testbench

ARRAY_REVERSE_CTRL -- requirements
Module: array_reverse_ctrl

---
 rtl/rev_pkg.sv | 11 +
 rtl/rev_frame_buf.sv | 34 +++
 rtl/array_reverse_ctrl.sv | 106 ++++++++++
 tb/tb_array_reverse_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rev_pkg.sv
// Shared constants for the array reverse controller: FSM state encoding
// and default frame geometry.
package rev_pkg;

  localparam int unsigned DEF_N     = 5;
  localparam int unsigned DEF_WIDTH = 8;

  localparam logic [0:0] LOAD  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

endpackage

// File: rtl/rev_frame_buf.sv
// Frame storage: N x WIDTH registers, one synchronous write port and one
// combinational read port. Contents are not reset.
//   clk    - clock
//   we     - write enable
//   waddr  - write index
//   wdata  - write data
//   raddr  - read index
//   rdata  - combinational read of the addressed register
module rev_frame_buf #(
  parameter int unsigned N     = 5,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IW    = $clog2(N)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [0:N-1];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port
  assign rdata = mem[raddr];

endmodule

// File: rtl/array_reverse_ctrl.sv
// Array reverse controller: collects N elements in LOAD, then emits them
// in reverse order in DRAIN. Input and output phases never overlap.
//   clk, rst             - clock, synchronous active-high reset
//   in_valid/in_ready    - upstream handshake, in_data element
//   out_valid/out_ready  - downstream handshake, out_data element
//   out_last             - presented element is the last of the frame
//   frame_done           - one-cycle pulse after the frame has drained
//   busy                 - high while in DRAIN
module array_reverse_ctrl
  import rev_pkg::*;
#(
  parameter int unsigned N     = DEF_N,
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             frame_done,
  output logic             busy
);

  localparam int unsigned  IW       = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  logic [0:0]    state_q,  state_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic          done_q,   done_d;
  logic          wr_en;

  // State and index registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LOAD;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      done_q   <= done_d;
    end
  end

  // Next-state and index update
  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    done_d   = 1'b0;
    wr_en    = 1'b0;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (wr_idx_q == LAST_IDX) begin
            state_d  = DRAIN;
            wr_idx_d = '0;
            rd_idx_d = LAST_IDX;
          end else begin
            wr_idx_d = wr_idx_q + IW'(1);
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (rd_idx_q == '0) begin
            state_d = LOAD;
            done_d  = 1'b1;
          end else begin
            rd_idx_d = rd_idx_q - IW'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Handshake outputs decode directly from the registered state
  assign in_ready   = (state_q == LOAD);
  assign out_valid  = (state_q == DRAIN);
  assign busy       = (state_q == DRAIN);
  assign out_last   = (state_q == DRAIN) && (rd_idx_q == '0);
  assign frame_done = done_q;

  rev_frame_buf #(
    .N     (N),
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_buf (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_idx_q),
    .wdata (in_data),
    .raddr (rd_idx_q),
    .rdata (out_data)
  );

endmodule

// File: tb/tb_array_reverse_ctrl.sv
// Directed bench for array_reverse_ctrl (N=5, WIDTH=8). Inputs are driven
// and outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_array_reverse_ctrl;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       frame_done;
  logic       busy;

  int vectors;
  int miscompares;

  array_reverse_ctrl #(.N(5), .WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .frame_done (frame_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({in_ready, out_valid, out_last, busy, frame_done} !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdy/vld/last/busy/done=%b expected 10000",
               {in_ready, out_valid, out_last, busy, frame_done});
    end
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({in_ready, out_valid, out_last, busy, frame_done} !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset_release: got rdy/vld/last/busy/done=%b expected 10000",
               {in_ready, out_valid, out_last, busy, frame_done});
    end
  endtask

  // Frame with in_valid and out_ready held high
  task automatic test_basic();
    logic [7:0] d [5];
    d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_load_%0d: got in_ready=%b busy=%b expected 1 0", i, in_ready, busy);
      end
      in_valid = 1'b1; in_data = d[i];
      @(negedge clk);
    end
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_data !== d[4-k] || out_last !== (k == 4) ||
          in_ready !== 1'b0 || busy !== 1'b1 || frame_done !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_out_%0d: got vld=%b data=%h last=%b rdy=%b busy=%b done=%b expected 1 %h %b 0 1 0",
                 k, out_valid, out_data, out_last, in_ready, busy, frame_done, d[4-k], (k == 4));
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    vectors++;
    if (frame_done !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done: got done=%b rdy=%b vld=%b busy=%b expected 1 1 0 0",
               frame_done, in_ready, out_valid, busy);
    end
    @(negedge clk);
    vectors++;
    if (frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done_pulse: got done=%b expected 0", frame_done);
    end
  endtask

  // Gaps on in_valid, out_ready pattern 1,0,0,1,0,0,...
  task automatic test_stall();
    logic [7:0] d [5];
    logic [7:0] prev;
    int idx;
    int k;
    bit stalled;
    d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    idx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 20 && idx < 5; c++) begin
      if (c % 2 == 0) begin
        in_valid = 1'b1; in_data = d[idx]; idx++;
      end else begin
        in_valid = 1'b0; in_data = 8'hC3;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    k = 0; stalled = 1'b0; prev = 8'h00;
    for (int c = 0; c < 30 && k < 5; c++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_data !== d[4-k] || out_last !== (k == 4) || frame_done !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_out_%0d: got vld=%b data=%h last=%b done=%b expected 1 %h %b 0",
                 k, out_valid, out_data, out_last, frame_done, d[4-k], (k == 4));
      end
      if (stalled) begin
        vectors++;
        if (out_data !== prev) begin
          miscompares++;
          $display("FAIL stall_hold_%0d: got data=%h expected %h", k, out_data, prev);
        end
      end
      prev = out_data;
      out_ready = (c % 3 == 0);
      stalled = !out_ready;
      if (out_ready) k++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    vectors++;
    if (k != 5 || frame_done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_done: got outputs=%0d done=%b busy=%b expected 5 1 0", k, frame_done, busy);
    end
    @(negedge clk);
  endtask

  // in_valid with 0xAA held high throughout DRAIN
  task automatic test_drain_ignore();
    logic [7:0] d [5];
    int k;
    d = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = d[i];
      @(negedge clk);
    end
    in_data = 8'hAA;
    k = 0;
    for (int c = 0; c < 20 && k < 5; c++) begin
      vectors++;
      if (in_ready !== 1'b0 || out_data === 8'hAA || out_data !== d[4-k]) begin
        miscompares++;
        $display("FAIL ignore_out_%0d: got rdy=%b data=%h expected 0 %h", k, in_ready, out_data, d[4-k]);
      end
      out_ready = (c % 2 == 1);
      if (out_ready) k++;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    vectors++;
    if (frame_done !== 1'b1 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ignore_done: got done=%b rdy=%b expected 1 1", frame_done, in_ready);
    end
    @(negedge clk);
  endtask

  // Reset after 3 inputs, then a clean frame
  task automatic test_reset_mid_load();
    logic [7:0] p [3];
    logic [7:0] d [5];
    p = '{8'h77, 8'h88, 8'h99};
    d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = p[i];
      @(negedge clk);
    end
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h66;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL rstload_state: got rdy=%b busy=%b done=%b expected 1 0 0", in_ready, busy, frame_done);
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (frame_done !== 1'b0 || in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL rstload_load_%0d: got done=%b rdy=%b expected 0 1", i, frame_done, in_ready);
      end
      in_valid = 1'b1; in_data = d[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_data !== d[4-k] || frame_done !== 1'b0 || out_last !== (k == 4)) begin
        miscompares++;
        $display("FAIL rstload_out_%0d: got vld=%b data=%h done=%b last=%b expected 1 %h 0 %b",
                 k, out_valid, out_data, frame_done, out_last, d[4-k], (k == 4));
      end
      @(negedge clk);
    end
    vectors++;
    if (frame_done !== 1'b1) begin
      miscompares++;
      $display("FAIL rstload_done: got done=%b expected 1", frame_done);
    end
    @(negedge clk);
  endtask

  // Reset during DRAIN after 2 outputs
  task automatic test_reset_mid_drain();
    logic [7:0] d [5];
    d = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = d[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (out_data !== d[4-k]) begin
        miscompares++;
        $display("FAIL rstdrain_out_%0d: got data=%h expected %h", k, out_data, d[4-k]);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({out_valid, in_ready, busy, frame_done, out_last} !== 5'b01000) begin
      miscompares++;
      $display("FAIL rstdrain_state: got vld/rdy/busy/done/last=%b expected 01000",
               {out_valid, in_ready, busy, frame_done, out_last});
    end
    @(negedge clk);
    vectors++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rstdrain_nodone: got done=%b busy=%b expected 0 0", frame_done, busy);
    end
  endtask

  // Two frames, second loaded starting on the frame_done cycle
  task automatic test_back_to_back();
    logic [7:0] a [5];
    logic [7:0] b [5];
    a = '{8'h01, 8'h12, 8'h23, 8'h34, 8'h45};
    b = '{8'h9A, 8'hAB, 8'hBC, 8'hCD, 8'hDE};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = a[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (out_data !== a[4-k] || dut.wr_idx_q > 3'd4 || dut.rd_idx_q > 3'd4) begin
        miscompares++;
        $display("FAIL b2b_a_out_%0d: got data=%h wr=%0d rd=%0d expected %h idx<=4",
                 k, out_data, dut.wr_idx_q, dut.rd_idx_q, a[4-k]);
      end
      @(negedge clk);
    end
    vectors++;
    if (frame_done !== 1'b1 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_ready_on_done: got done=%b rdy=%b expected 1 1", frame_done, in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (in_ready !== 1'b1 || dut.wr_idx_q > 3'd4) begin
        miscompares++;
        $display("FAIL b2b_b_load_%0d: got rdy=%b wr=%0d expected 1 <=4", i, in_ready, dut.wr_idx_q);
      end
      in_valid = 1'b1; in_data = b[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_data !== b[4-k] || out_last !== (k == 4) || dut.rd_idx_q > 3'd4) begin
        miscompares++;
        $display("FAIL b2b_b_out_%0d: got vld=%b data=%h last=%b rd=%0d expected 1 %h %b <=4",
                 k, out_valid, out_data, out_last, dut.rd_idx_q, b[4-k], (k == 4));
      end
      @(negedge clk);
    end
    vectors++;
    if (frame_done !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_b_done: got done=%b expected 1", frame_done);
    end
    @(negedge clk);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_drain_ignore();
    test_reset_mid_load();
    test_reset_mid_drain();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
